weight_load_sched: RTL and testbench
====================================

// Module: weight_load_sched
// PURPOSE
// - Sequences one conv layer on the weight path: streams weights into the weight BRAM write port, kicks the SA controller, then waits for conv completion.
// - Sits between the external weight DMA stream and the weight-stationary top (drives its wea/dia/addra, start_i and nth_conv_i; consumes conv_done_i).
// - Owns the BRAM write port for the whole layer; the write and read phases never overlap.
// PARAMETERS
// - DATA_WIDTH    8    weight word width
// - BAND_WT_WIDTH 16   max SA columns (BRAM column banks)
// - ROW_DEPTH     256  max rows per column bank
// - ADDR_WIDTH    12   BRAM address width: [11:8] column, [7:0] row
// PORTS
// - clk          in   1           single clock, rising edge
// - rst          in   1           synchronous, active-high reset
// - start_i      in   1           layer request pulse; accepted only in IDLE
// - nth_conv_i   in   2           layer index, latched at accepted start
// - num_rows_i   in   9           rows per column, 1..ROW_DEPTH, latched at start
// - num_cols_i   in   5           columns, 1..BAND_WT_WIDTH, latched at start
// - s_valid_i    in   1           weight stream valid
// - s_data_i     in   DATA_WIDTH  weight stream data
// - s_last_i     in   1           final beat of the layer's weights
// - s_ready_o    out  1           weight stream ready
// - wea_o        out  1           BRAM write enable
// - dia_o        out  DATA_WIDTH  BRAM write data
// - addra_o      out  ADDR_WIDTH  BRAM write address
// - sa_start_o   out  1           one-cycle start pulse to the SA controller
// - nth_conv_o   out  2           latched layer index
// - conv_done_i  in   1           SA controller layer-complete pulse
// - busy_o       out  1           high in any state except IDLE
// - done_o       out  1           one-cycle pulse at layer completion
// - err_o        out  1           sticky error, cleared by the next accepted start
// BEHAVIOUR
// - Reset: FSM to IDLE; all outputs and counters 0; err_o 0.
// - States: IDLE -> LOAD -> KICK -> RUN -> DONE -> IDLE.
// - IDLE: on start_i, if 1<=num_rows_i<=ROW_DEPTH and 1<=num_cols_i<=BAND_WT_WIDTH: latch cfg and nth_conv, clear err_o and row/col counters, go to LOAD.
// - Invalid cfg at start_i: err_o=1; stay in IDLE. start_i outside IDLE is ignored.
// - LOAD: s_ready_o=1. Beat = s_valid_i && s_ready_o.
// - Each beat registers wea_o=1, dia_o=s_data_i, addra_o={col[3:0],row[7:0]} on the next cycle (latency 1). wea_o=0 on cycles with no beat.
// - Write order is column-major: row increments 0..num_rows-1, then wraps to 0 while col increments.
// - Final beat (row==num_rows-1 && col==num_cols-1): s_ready_o drops the next cycle; go to KICK. s_last_i low on that beat: err_o=1, flow continues.
// - s_last_i high on any earlier beat: that beat is still written; err_o=1; abort to IDLE without kick (busy_o falls, no done_o).
// - KICK: sa_start_o=1 for exactly one cycle, one cycle after the last wea_o; go to RUN.
// - RUN: s_ready_o=0; wait for conv_done_i; then go to DONE. conv_done_i is ignored in every other state.
// - DONE: done_o=1 for one cycle; go to IDLE. A start_i in that cycle is ignored; the earliest accepted next start is the following cycle.
// - nth_conv_o holds its latched value until the next accepted start.
// - Reset mid-operation (any state) returns to IDLE on the next edge. No partial-layer state is kept.
// STRUCTURE
// - Shared package weight_pkg: state enum typedef (IDLE, LOAD, KICK, RUN, DONE), ADDR_WIDTH, and the row/col field positions of the BRAM address.
// - Single flat module; the row/col address counter is the one natural sub-module: wt_addr_cnt (inc, clear, wrap, terminal-count flag).
// TESTING
// - rows=25, cols=6, 150 beats with s_valid_i held high, s_last_i on beat 150 -> 150 wea_o pulses, addresses 0x000..0x018 then 0x100.., last 0x518; one sa_start_o; err_o=0.
// - Same cfg with random s_valid_i gaps -> identical address/data sequence; wea_o only on beat cycles.
// - rows=256, cols=16 -> address wraps 0x0FF->0x100; last address 0xFFF; exactly 4096 writes.
// - s_last_i on beat 10 of 150 -> 10 writes, err_o=1, no sa_start_o, no done_o, busy_o=0.
// - num_cols_i=0 or num_rows_i=300 at start_i -> err_o=1, busy_o stays 0, no writes.
// - conv_done_i pulsed during LOAD, then in RUN; start_i pulsed during RUN; rst pulsed mid-LOAD -> only the RUN conv_done_i gives done_o; the RUN start_i is ignored; rst zeroes all outputs next cycle.

Source files
------------

// File: rtl/weight_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : weight_pkg                                                 |
// | Shared types and BRAM address layout for the weight load sequencer.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package weight_pkg;

  // BRAM write address: [11:8] column bank, [7:0] row within the bank
  localparam int ADDR_WIDTH = 12;
  localparam int ROW_LSB    = 0;
  localparam int ROW_W      = 8;
  localparam int COL_LSB    = 8;
  localparam int COL_W      = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    KICK = 3'd2,
    RUN  = 3'd3,
    DONE = 3'd4
  } state_t;

  // Assemble a BRAM address from its column and row fields
  function automatic logic [ADDR_WIDTH-1:0] pack_addr(input logic [COL_W-1:0] col,
                                                      input logic [ROW_W-1:0] row);
    logic [ADDR_WIDTH-1:0] a;
    a = '0;
    a[COL_LSB +: COL_W] = col;
    a[ROW_LSB +: ROW_W] = row;
    return a;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wt_addr_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : wt_addr_cnt                                                |
// | Column-major row/column counter for the weight BRAM write address.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module wt_addr_cnt
  import weight_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             inc_i,
  input  logic [ROW_W-1:0] last_row_i,
  input  logic [COL_W-1:0] last_col_i,
  output logic [ROW_W-1:0] row_o,
  output logic [COL_W-1:0] col_o,
  output logic             wrap_o,
  output logic             tc_o
);

  logic [ROW_W-1:0] row_q;
  logic [COL_W-1:0] col_q;

  // Row advances every increment; on reaching the last row it wraps and the column steps
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      row_q <= '0;
      col_q <= '0;
    end else if (inc_i) begin
      if (wrap_o) begin
        row_q <= '0;
        col_q <= col_q + 1'b1;
      end else begin
        row_q <= row_q + 1'b1;
      end
    end
  end

  assign row_o  = row_q;
  assign col_o  = col_q;
  assign wrap_o = (row_q == last_row_i);
  assign tc_o   = wrap_o && (col_q == last_col_i);

endmodule
`default_nettype wire

// File: rtl/weight_load_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : weight_load_sched                                          |
// | Streams one layer of weights into the weight BRAM, kicks the SA      |
// | controller, then waits for conv completion.                          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module weight_load_sched
  import weight_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int BAND_WT_WIDTH = 16,
  parameter int ROW_DEPTH     = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [1:0]            nth_conv_i,
  input  logic [8:0]            num_rows_i,
  input  logic [4:0]            num_cols_i,
  input  logic                  s_valid_i,
  input  logic [DATA_WIDTH-1:0] s_data_i,
  input  logic                  s_last_i,
  output logic                  s_ready_o,
  output logic                  wea_o,
  output logic [DATA_WIDTH-1:0] dia_o,
  output logic [ADDR_WIDTH-1:0] addra_o,
  output logic                  sa_start_o,
  output logic [1:0]            nth_conv_o,
  input  logic                  conv_done_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  state_t                state_q, state_d;
  logic [ROW_W-1:0]      last_row_q;
  logic [COL_W-1:0]      last_col_q;
  logic [1:0]            nth_conv_q;
  logic                  err_q;
  logic                  wea_q;
  logic [DATA_WIDTH-1:0] dia_q;
  logic [ADDR_WIDTH-1:0] addra_q;
  logic                  sa_start_q, sa_start_d;

  logic [ROW_W-1:0]      w_row;
  logic [COL_W-1:0]      w_col;
  logic                  w_wrap;
  logic                  w_tc;

  // A count of ROW_DEPTH/BAND_WT_WIDTH truncates to 0 in the low bits, so minus one gives the all-ones last index
  logic                  w_cfg_ok;
  logic                  w_start_idle;
  logic                  w_start_ok;
  logic                  w_beat;

  assign w_cfg_ok     = (num_rows_i != 9'd0) && (num_rows_i <= 9'(ROW_DEPTH)) &&
                        (num_cols_i != 5'd0) && (num_cols_i <= 5'(BAND_WT_WIDTH));
  assign w_start_idle = start_i && (state_q == IDLE);
  assign w_start_ok   = w_start_idle && w_cfg_ok;
  assign w_beat       = s_valid_i && (state_q == LOAD);

  wt_addr_cnt u_addr_cnt (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (w_start_ok),
    .inc_i      (w_beat),
    .last_row_i (last_row_q),
    .last_col_i (last_col_q),
    .row_o      (w_row),
    .col_o      (w_col),
    .wrap_o     (w_wrap),
    .tc_o       (w_tc)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state: an early s_last aborts the layer, the terminal beat moves on to the kick
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (w_start_ok) state_d = LOAD;
      LOAD: begin
        if (w_beat) begin
          if (w_tc)          state_d = KICK;
          else if (s_last_i) state_d = IDLE;
        end
      end
      KICK: state_d = RUN;
      RUN:  if (conv_done_i) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State-decoded outputs; the kick is registered so it lands one cycle after the last write
  always_comb begin
    s_ready_o  = (state_q == LOAD);
    busy_o     = (state_q != IDLE);
    done_o     = (state_q == DONE);
    sa_start_d = (state_q == KICK);
  end

  // Layer configuration captured at an accepted start
  always_ff @(posedge clk) begin
    if (rst) begin
      last_row_q <= '0;
      last_col_q <= '0;
      nth_conv_q <= '0;
    end else if (w_start_ok) begin
      last_row_q <= num_rows_i[ROW_W-1:0] - 1'b1;
      last_col_q <= num_cols_i[COL_W-1:0] - 1'b1;
      nth_conv_q <= nth_conv_i;
    end
  end

  // Sticky error: bad config, missing s_last on the final beat, or s_last arriving early
  always_ff @(posedge clk) begin
    if (rst)                                        err_q <= 1'b0;
    else if (w_start_ok)                            err_q <= 1'b0;
    else if (w_start_idle)                          err_q <= 1'b1;
    else if (w_beat && (w_tc ? !s_last_i : s_last_i)) err_q <= 1'b1;
  end

  // BRAM write port and kick pulse, one cycle behind the accepted beat
  always_ff @(posedge clk) begin
    if (rst) begin
      wea_q      <= 1'b0;
      dia_q      <= '0;
      addra_q    <= '0;
      sa_start_q <= 1'b0;
    end else begin
      wea_q      <= w_beat;
      sa_start_q <= sa_start_d;
      if (w_beat) begin
        dia_q   <= s_data_i;
        addra_q <= pack_addr(w_col, w_row);
      end
    end
  end

  assign wea_o      = wea_q;
  assign dia_o      = dia_q;
  assign addra_o    = addra_q;
  assign sa_start_o = sa_start_q;
  assign nth_conv_o = nth_conv_q;
  assign err_o      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_weight_load_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_weight_load_sched                                       |
// | Directed self-checking bench for weight_load_sched.                  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_weight_load_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [1:0]  nth_conv_i;
  logic [8:0]  num_rows_i;
  logic [4:0]  num_cols_i;
  logic        s_valid_i;
  logic [7:0]  s_data_i;
  logic        s_last_i;
  logic        s_ready_o;
  logic        wea_o;
  logic [7:0]  dia_o;
  logic [11:0] addra_o;
  logic        sa_start_o;
  logic [1:0]  nth_conv_o;
  logic        conv_done_i;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  weight_load_sched dut (
    .clk(clk), .rst(rst), .start_i(start_i), .nth_conv_i(nth_conv_i),
    .num_rows_i(num_rows_i), .num_cols_i(num_cols_i),
    .s_valid_i(s_valid_i), .s_data_i(s_data_i), .s_last_i(s_last_i), .s_ready_o(s_ready_o),
    .wea_o(wea_o), .dia_o(dia_o), .addra_o(addra_o), .sa_start_o(sa_start_o),
    .nth_conv_o(nth_conv_o), .conv_done_i(conv_done_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int timeouts = 0;

  // Write-port monitor sampled on the falling edge
  logic [11:0] addr_q[$];
  logic [7:0]  data_q[$];
  int cyc = 0, sa_cnt = 0, done_cnt = 0, wea_bad = 0, last_wea_cyc = 0, sa_cyc = 0;
  bit mon_en = 0;
  logic prev_beat = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      if (wea_o !== prev_beat) wea_bad++;
      if (wea_o === 1'b1) begin
        addr_q.push_back(addra_o);
        data_q.push_back(dia_o);
        last_wea_cyc = cyc;
      end
      if (sa_start_o === 1'b1) begin sa_cnt++; sa_cyc = cyc; end
      if (done_o === 1'b1) done_cnt++;
    end
    prev_beat = s_valid_i && s_ready_o && !rst;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_data(input int k);
    return 8'((k * 7 + 3) & 8'hFF);
  endfunction

  function automatic logic [31:0] exp_addr(input int k, input int rows);
    return 32'((k / rows) * 256 + (k % rows));
  endfunction

  function automatic logic [31:0] qa(input int i);
    if (i >= 0 && i < addr_q.size()) return 32'(addr_q[i]);
    return 32'hDEADBEEF;
  endfunction

  // Count entries from base that differ from the expected column-major sequence
  function automatic int seq_errs(input int base, input int rows, input int n);
    int e = 0;
    for (int k = 0; k < n; k++) begin
      if (base + k >= addr_q.size()) e++;
      else if (32'(addr_q[base + k]) !== exp_addr(k, rows) || data_q[base + k] !== exp_data(k)) e++;
    end
    return e;
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_layer(input logic [1:0] nth, input logic [8:0] rows, input logic [4:0] cols);
    start_i = 1'b1; nth_conv_i = nth; num_rows_i = rows; num_cols_i = cols;
    cycles(1);
    start_i = 1'b0;
  endtask

  // Drive n beats; beat number last_at (1-based) carries s_last
  task automatic send_beats(input int n, input int last_at, input bit gaps);
    for (int k = 0; k < n; k++) begin
      bit got = 0;
      int t = 0;
      if (gaps && ($urandom_range(0, 2) == 0)) begin
        s_valid_i = 1'b0;
        cycles($urandom_range(1, 3));
      end
      s_valid_i = 1'b1; s_data_i = exp_data(k); s_last_i = (k + 1 == last_at);
      while (!got && t < 20) begin
        @(negedge clk);
        got = s_ready_o;
        @(posedge clk); #1;
        t++;
      end
      if (!got) timeouts++;
    end
    s_valid_i = 1'b0; s_last_i = 1'b0;
  endtask

  task automatic pulse_done();
    conv_done_i = 1'b1;
    cycles(1);
    conv_done_i = 1'b0;
  endtask

  int b0, s0, d0;

  initial begin
    rst = 1'b1; start_i = 0; nth_conv_i = 0; num_rows_i = 0; num_cols_i = 0;
    s_valid_i = 0; s_data_i = 0; s_last_i = 0; conv_done_i = 0;
    cycles(3);
    @(negedge clk);
    chk("rst_busy", busy_o, 0);   chk("rst_ready", s_ready_o, 0);
    chk("rst_wea", wea_o, 0);     chk("rst_addr", addra_o, 0);
    chk("rst_err", err_o, 0);     chk("rst_nth", nth_conv_o, 0);
    chk("rst_sa", sa_start_o, 0); chk("rst_done", done_o, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    mon_en = 1;
    cycles(2);

    // 25x6 layer, continuous stream
    b0 = addr_q.size(); s0 = sa_cnt; d0 = done_cnt;
    start_layer(2'd2, 9'd25, 5'd6);
    send_beats(150, 150, 0);
    cycles(3);
    @(negedge clk);
    chk("A_writes", addr_q.size() - b0, 150);
    chk("A_first", qa(b0), 32'h000);
    chk("A_row_end", qa(b0 + 24), 32'h018);
    chk("A_col1", qa(b0 + 25), 32'h100);
    chk("A_last", qa(b0 + 149), 32'h518);
    chk("A_seq", seq_errs(b0, 25, 150), 0);
    chk("A_kick_cnt", sa_cnt - s0, 1);
    chk("A_kick_lat", sa_cyc - last_wea_cyc, 1);
    chk("A_err", err_o, 0);
    chk("A_nth", nth_conv_o, 2);
    chk("A_busy_run", busy_o, 1);
    chk("A_no_done_yet", done_cnt - d0, 0);
    @(posedge clk); #1;
    pulse_done();
    cycles(2);
    @(negedge clk);
    chk("A_done", done_cnt - d0, 1);
    chk("A_idle", busy_o, 0);
    @(posedge clk); #1;

    // Same layer with random valid gaps
    b0 = addr_q.size(); s0 = sa_cnt;
    start_layer(2'd1, 9'd25, 5'd6);
    send_beats(150, 150, 1);
    cycles(3);
    pulse_done();
    cycles(2);
    @(negedge clk);
    chk("B_writes", addr_q.size() - b0, 150);
    chk("B_seq", seq_errs(b0, 25, 150), 0);
    chk("B_wea_only_beats", wea_bad, 0);
    chk("B_kick_cnt", sa_cnt - s0, 1);
    @(posedge clk); #1;

    // Invalid: zero columns
    b0 = addr_q.size();
    start_layer(2'd3, 9'd25, 5'd0);
    cycles(3);
    @(negedge clk);
    chk("E1_err", err_o, 1);
    chk("E1_busy", busy_o, 0);
    chk("E1_writes", addr_q.size() - b0, 0);
    @(posedge clk); #1;

    // Full 256x16 layer; a valid start clears the earlier error
    b0 = addr_q.size();
    start_layer(2'd3, 9'd256, 5'd16);
    @(negedge clk);
    chk("C_err_clear", err_o, 0);
    @(posedge clk); #1;
    send_beats(4096, 4096, 0);
    cycles(3);
    pulse_done();
    cycles(2);
    @(negedge clk);
    chk("C_writes", addr_q.size() - b0, 4096);
    chk("C_wrap_lo", qa(b0 + 255), 32'h0FF);
    chk("C_wrap_hi", qa(b0 + 256), 32'h100);
    chk("C_last", qa(b0 + 4095), 32'hFFF);
    chk("C_seq", seq_errs(b0, 256, 4096), 0);
    chk("C_err", err_o, 0);
    @(posedge clk); #1;

    // Invalid: 300 rows
    b0 = addr_q.size();
    start_layer(2'd0, 9'd300, 5'd4);
    cycles(3);
    @(negedge clk);
    chk("E2_err", err_o, 1);
    chk("E2_busy", busy_o, 0);
    chk("E2_writes", addr_q.size() - b0, 0);
    @(posedge clk); #1;

    // Early s_last on beat 10 aborts the layer
    b0 = addr_q.size(); s0 = sa_cnt; d0 = done_cnt;
    start_layer(2'd0, 9'd25, 5'd6);
    send_beats(10, 10, 0);
    cycles(4);
    @(negedge clk);
    chk("D_writes", addr_q.size() - b0, 10);
    chk("D_err", err_o, 1);
    chk("D_no_kick", sa_cnt - s0, 0);
    chk("D_no_done", done_cnt - d0, 0);
    chk("D_busy", busy_o, 0);
    @(posedge clk); #1;

    // Reset in IDLE clears the sticky error
    rst = 1'b1; cycles(1); rst = 1'b0;
    @(negedge clk);
    chk("R_err_clear", err_o, 0);
    @(posedge clk); #1;

    // conv_done in LOAD ignored, start in RUN/DONE ignored
    b0 = addr_q.size(); s0 = sa_cnt; d0 = done_cnt;
    start_layer(2'd3, 9'd2, 5'd1);
    pulse_done();
    send_beats(2, 2, 0);
    cycles(3);
    start_layer(2'd1, 9'd4, 5'd1);
    @(negedge clk);
    chk("F_busy_run", busy_o, 1);
    chk("F_nth_hold", nth_conv_o, 3);
    chk("F_load_done_ign", done_cnt - d0, 0);
    @(posedge clk); #1;
    conv_done_i = 1'b1; cycles(1); conv_done_i = 1'b0;
    start_i = 1'b1; nth_conv_i = 2'd1; num_rows_i = 9'd4; num_cols_i = 5'd1;
    cycles(1);
    start_i = 1'b0;
    @(negedge clk);
    chk("F_done", done_cnt - d0, 1);
    chk("F_done_start_ign", busy_o, 0);
    chk("F_writes", addr_q.size() - b0, 2);
    chk("F_nth_after", nth_conv_o, 3);
    @(posedge clk); #1;

    // Reset in the middle of LOAD
    start_layer(2'd2, 9'd25, 5'd6);
    send_beats(3, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("M_pre_busy", busy_o, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("M_busy", busy_o, 0);   chk("M_ready", s_ready_o, 0);
    chk("M_wea", wea_o, 0);     chk("M_addr", addra_o, 0);
    chk("M_dia", dia_o, 0);     chk("M_nth", nth_conv_o, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    cycles(3);
    @(negedge clk);
    chk("M_stay_idle", busy_o, 0);

    chk("stream_timeouts", timeouts, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
